// File: rtl/gcd_seq_pkg.sv
// ----------------------------------------------------------------------------
// gcd_seq_pkg
// Shared definitions for the GCD sequencer:
//   - default WIDTH / TIMEOUT / CNT_W values
//   - state_t : sequencer FSM states
// No ports (package).
// ----------------------------------------------------------------------------
package gcd_seq_pkg;

    localparam int DEF_WIDTH   = 16;     // operand/result width of the GCD datapath
    localparam int DEF_TIMEOUT = 70000;  // RUN cycles allowed before abort
    localparam int DEF_CNT_W   = 17;     // wide enough to reach DEF_TIMEOUT without wrap

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for an operand pair
        LOAD = 2'd1,  // one-cycle load strobe into the GCD
        RUN  = 2'd2,  // GCD iterating, cycle counter running
        DONE = 2'd3   // result presented until the consumer takes it
    } state_t;

endpackage : gcd_seq_pkg

// File: rtl/gcd_sequencer_if.sv
// ----------------------------------------------------------------------------
// gcd_sequencer_if
// Bundles the sequencer's handshake and GCD-side signals.
//   Operand side : in_valid, in_ready, in_a, in_b
//   Result side  : out_valid, out_ready, out_z, out_err, out_cycles
//   GCD side     : gcd_a, gcd_b, gcd_e (to GCD), gcd_z, gcd_v (from GCD)
// Modports:
//   master : the sequencer itself
//   slave  : its surroundings (producer, consumer and the GCD instance)
// ----------------------------------------------------------------------------
interface gcd_sequencer_if #(
    parameter int WIDTH = gcd_seq_pkg::DEF_WIDTH,
    parameter int CNT_W = gcd_seq_pkg::DEF_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_err;
    logic [CNT_W-1:0] out_cycles;

    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_e;
    logic [WIDTH-1:0] gcd_z;
    logic             gcd_v;

    modport master (
        input  in_valid, in_a, in_b, out_ready, gcd_z, gcd_v,
        output in_ready, out_valid, out_z, out_err, out_cycles, gcd_a, gcd_b, gcd_e
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, gcd_z, gcd_v,
        input  in_ready, out_valid, out_z, out_err, out_cycles, gcd_a, gcd_b, gcd_e
    );

endinterface : gcd_sequencer_if

// File: rtl/gcd_sequencer.sv
// ----------------------------------------------------------------------------
// gcd_sequencer
// Drives an iterative GCD core that sits beside it at the parent level:
// accepts one operand pair, pulses the GCD load strobe for one cycle, counts
// RUN cycles until the GCD reports valid (or the count reaches TIMEOUT), then
// holds the result until the consumer takes it. A zero first operand is
// answered directly (out_z = in_b) because the GCD never terminates for it.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : gcd_sequencer_if.master (operand, result and GCD-side signals)
// ----------------------------------------------------------------------------
module gcd_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    gcd_sequencer_if.master bus
);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    logic [WIDTH-1:0] res_z;
    logic             res_err;
    logic [CNT_W-1:0] res_cycles;

    // The result counts the RUN cycle in which gcd_v is seen, so the compare
    // and the captured cycle count both use the incremented value.
    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Operand, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            res_z      <= '0;
            res_err    <= 1'b0;
            res_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a <= bus.in_a;
                        op_b <= bus.in_b;
                        // Counter starts from zero for the LOAD that follows.
                        cnt  <= '0;
                        if (bus.in_a == '0) begin
                            res_z      <= bus.in_b;
                            res_err    <= 1'b0;
                            res_cycles <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt_inc;
                    // gcd_v wins over a timeout landing in the same cycle.
                    if (bus.gcd_v) begin
                        res_z      <= bus.gcd_z;
                        res_err    <= 1'b0;
                        res_cycles <= cnt_inc;
                    end else if (timeout_hit) begin
                        res_z      <= '0;
                        res_err    <= 1'b1;
                        res_cycles <= cnt_inc;
                    end
                end
                default: ;  // LOAD and DONE hold everything
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_next     = state;
        bus.in_ready   = 1'b0;
        bus.gcd_e      = 1'b0;
        bus.out_valid  = 1'b0;
        bus.gcd_a      = op_a;
        bus.gcd_b      = op_b;
        bus.out_z      = res_z;
        bus.out_err    = res_err;
        bus.out_cycles = res_cycles;

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = (bus.in_a == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // gcd_v still reflects the previous job here; it is ignored.
                bus.gcd_e  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (bus.gcd_v || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule : gcd_sequencer

// File: tb/tb_gcd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gcd_sequencer
// Self-checking bench: a behavioural subtract-and-swap GCD core sits beside
// the sequencer; expected results are pushed to a scoreboard when an operand
// pair is accepted and compared when the sequencer presents its result.
// The DUT runs with TIMEOUT=5 so both the abort path and the
// gcd_v-versus-timeout tie are reachable with small operands.
// ----------------------------------------------------------------------------
module tb_gcd_sequencer;

    localparam int WIDTH   = 16;
    localparam int CNT_W   = 17;
    localparam int TIMEOUT = 5;
    localparam int MAX_WAIT = 200;

    typedef struct {
        logic [WIDTH-1:0] z;
        logic             err;
        logic [CNT_W-1:0] cyc;
        int               lat;     // negedges from acceptance to out_valid
        int               pulses;  // gcd_e pulses expected for this job
    } exp_t;

    logic clk;
    logic reset;

    gcd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

    gcd_sequencer #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural GCD core (not reset: stale contents must be ignored).
    logic [WIDTH-1:0] gx = '0;
    logic [WIDTH-1:0] gy = '0;

    always @(posedge clk) begin
        if (bus_if.gcd_e) begin
            gx <= bus_if.gcd_a;
            gy <= bus_if.gcd_b;
        end else if (gx > gy) begin
            gx <= gx - gy;
        end else begin
            gy <= gy - gx;
        end
    end

    assign bus_if.gcd_z = gx;
    assign bus_if.gcd_v = (gy == '0);

    int e_count = 0;
    always @(posedge clk) begin
        if (bus_if.gcd_e) e_count <= e_count + 1;
    end

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Expected outcome of one operand pair.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t             e;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        int               c;
        if (a == '0) begin
            e.z = b; e.err = 1'b0; e.cyc = '0; e.lat = 1; e.pulses = 0;
            return e;
        end
        x = a; y = b; c = 1;
        while (y != '0 && c < TIMEOUT) begin
            if (x > y) x = x - y;
            else       y = y - x;
            c++;
        end
        e.pulses = 1;
        if (y == '0) begin
            e.z = x; e.err = 1'b0; e.cyc = CNT_W'(c);
        end else begin
            e.z = '0; e.err = 1'b1; e.cyc = CNT_W'(TIMEOUT);
        end
        e.lat = int'(e.cyc) + 2;
        return e;
    endfunction

    // Offer a pair at a negedge; returns at the negedge after acceptance.
    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int e_before);
        check("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
        e_before       = e_count;
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    // Wait for the result, hold out_ready low for 'hold' cycles, then take it.
    task automatic collect(input int hold, input int e_before);
        exp_t e;
        int   lat;
        lat = 1;
        while (!bus_if.out_valid && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!bus_if.out_valid) begin
            check("out_valid_timeout", 32'(bus_if.out_valid), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(e.lat));
        check("out_z", 32'(bus_if.out_z), 32'(e.z));
        check("out_err", 32'(bus_if.out_err), 32'(e.err));
        check("out_cycles", 32'(bus_if.out_cycles), 32'(e.cyc));
        check("gcd_e_pulses", 32'(e_count - e_before), 32'(e.pulses));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus_if.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
            check("hold_z", 32'(bus_if.out_z), 32'(e.z));
            check("hold_err", 32'(bus_if.out_err), 32'(e.err));
            check("hold_cycles", 32'(bus_if.out_cycles), 32'(e.cyc));
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check("valid_dropped", 32'(bus_if.out_valid), 32'd0);
        check("back_idle", 32'(bus_if.in_ready), 32'd1);
    endtask

    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
        int eb;
        offer(a, b, eb);
        collect(hold, eb);
    endtask

    initial begin
        int eb;
        reset            = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_err", 32'(bus_if.out_err), 32'd0);
        check("rst_out_z", 32'(bus_if.out_z), 32'd0);
        check("rst_out_cycles", 32'(bus_if.out_cycles), 32'd0);
        check("rst_gcd_e", 32'(bus_if.gcd_e), 32'd0);
        check("rst_gcd_a", 32'(bus_if.gcd_a), 32'd0);
        check("rst_gcd_b", 32'(bus_if.gcd_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

        run_txn(16'd12, 16'd8, 3);      // basic, result held until out_ready
        run_txn(16'd0, 16'd9, 0);       // bypass, no gcd_e
        run_txn(16'd7, 16'd0, 0);       // immediate valid, 1 cycle
        run_txn(16'd65535, 16'd1, 1);   // timeout abort
        run_txn(16'd0, 16'd0, 0);       // bypass with zero result

        // Reset in the middle of RUN of 100/75, then a fresh pair.
        offer(16'd100, 16'd75, eb);
        @(negedge clk);                 // now in RUN
        check("mid_run_busy", 32'(bus_if.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus_if.in_ready), 32'd1);
        check("mid_rst_gcd_e", 32'(bus_if.gcd_e), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn(16'd21, 16'd14, 0);

        run_txn(16'd100, 16'd75, 0);    // gcd_v coincides with timeout count
        run_txn(16'd9, 16'd6, 10);      // long back-pressure in DONE

        for (int i = 0; i < 10; i++) begin
            run_txn(16'($urandom_range(1, 40)), 16'($urandom_range(0, 40)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gcd_sequencer

// File: doc/gcd_sequencer.md
GCD_SEQUENCER -- requirements
Module: gcd_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand/result width (matches GCD datapath).
REQ-002 SHALL have parameter TIMEOUT, 70000, maximum RUN cycles before abort.
REQ-003 SHALL have parameter CNT_W, 17, cycle-counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand pair offered.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts operands.
REQ-008 SHALL have ports in_a, in_b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_z  output  WIDTH  GCD result (0 on error).
REQ-012 SHALL have port out_err  output  1  timeout abort flag, qualified by out_valid.
REQ-013 SHALL have port out_cycles  output  CNT_W  RUN cycles spent, qualified by out_valid.
REQ-014 SHALL have ports gcd_a, gcd_b  output  WIDTH  to GCD io_a/io_b.
REQ-015 SHALL have port gcd_e  output  1  to GCD io_e (load strobe).
REQ-016 SHALL have ports gcd_z  input  WIDTH, gcd_v  input  1  from GCD io_z/io_v.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-018 IDLE SHALL assert in_ready=1; on in_valid latch in_a/in_b; if in_a==0 go DONE with out_z=in_b, out_cycles=0 (bypass: GCD never terminates for x=0, y!=0); else go LOAD.
REQ-019 LOAD SHALL last exactly one cycle with gcd_e=1 and gcd_a/gcd_b = latched operands; gcd_v SHALL be ignored in LOAD.
REQ-020 RUN SHALL hold gcd_e=0, increment counter each cycle, and on gcd_v=1 capture gcd_z into out_z, counter into out_cycles, and go DONE.
REQ-021 RUN SHALL, when counter reaches TIMEOUT with gcd_v=0, go DONE with out_err=1, out_z=0.
REQ-022 gcd_v=1 in RUN takes priority over the timeout in the same cycle.
REQ-023 DONE SHALL assert out_valid=1 with out_z/out_err/out_cycles stable until out_ready=1, then go IDLE next cycle.
REQ-024 in_ready SHALL be 0 in LOAD, RUN, DONE; no operand acceptance overlaps an active computation.
REQ-025 gcd_a/gcd_b SHALL hold latched operands outside LOAD (value irrelevant to GCD while gcd_e=0).
REQ-026 Counter SHALL be cleared on entry to LOAD; no arithmetic wrap within TIMEOUT.
REQ-027 Result (out_valid) SHALL appear the cycle after gcd_v is sampled high in RUN.

Reset
REQ-028 Reset SHALL force IDLE asynchronously at any state, including mid-RUN.
REQ-029 Reset values: in_ready=1 after release, out_valid=0, out_err=0, out_z=0, out_cycles=0, gcd_e=0, gcd_a=0, gcd_b=0, counter=0.
REQ-030 Stale GCD register contents after reset SHALL be ignored until a fresh LOAD.

Structure
REQ-031 Package gcd_seq_pkg SHALL hold the state enum and default WIDTH/TIMEOUT/CNT_W constants.
REQ-032 No sub-module; counter and FSM inline; GCD instantiated at the parent level beside this block.

Verification
REQ-033 a=12, b=8 -> out_z=4, out_err=0, out_valid held until out_ready.
REQ-034 a=0, b=9 -> bypass, out_z=9, out_cycles=0, gcd_e never pulsed.
REQ-035 a=7, b=0 -> out_z=7, out_cycles=1.
REQ-036 TIMEOUT=5, a=65535, b=1 -> out_err=1, out_z=0, out_cycles=5.
REQ-037 reset asserted mid-RUN of a=100, b=75 -> out_valid=0 immediately; next pair a=21, b=14 -> out_z=7.
REQ-038 out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0 throughout.
